// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared core constants: XLEN, RV32M funct3 encodings, muldiv FSM states
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/rv32_muldiv_negate.sv
// rtl/rv32_muldiv_negate.sv - conditional two's-complement, used for operand magnitudes and result sign fix
module rv32_muldiv_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/rv32_muldiv.sv
// rtl/rv32_muldiv.sv - iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide
module rv32_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic            o_write,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_result
);
  import rv32_pkg::*;

  md_state_e           state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;

  logic                signed1, signed2, s1, s2, is_rem_in, div_zero, div_ovf, accept;
  logic [XLEN-1:0]     mag1, mag2;

  assign signed1   = !(i_funct3 == F3_MULHU || i_funct3 == F3_DIVU || i_funct3 == F3_REMU);
  assign signed2   = (i_funct3 == F3_MUL || i_funct3 == F3_MULH ||
                      i_funct3 == F3_DIV || i_funct3 == F3_REM);
  assign s1        = signed1 & i_rs1[XLEN-1];
  assign s2        = signed2 & i_rs2[XLEN-1];
  assign is_rem_in = i_funct3[2] & i_funct3[1];
  assign div_zero  = i_funct3[2] && (i_rs2 == '0);
  assign div_ovf   = (i_funct3 == F3_DIV || i_funct3 == F3_REM) &&
                     (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign accept    = i_start && !i_flush && (state_q != MD_CALC);

  rv32_muldiv_negate #(.W(XLEN)) u_mag1 (.i_neg(s1), .i_val(i_rs1), .o_val(mag1));
  rv32_muldiv_negate #(.W(XLEN)) u_mag2 (.i_neg(s2), .i_val(i_rs2), .o_val(mag2));

  // Multiply step: acc = {partial_hi, multiplier bits still to consume}.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [XLEN:0]       div_r;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   div_next;
  assign div_r    = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_r >= {1'b0, b_q};
  assign div_diff = div_r[XLEN-1:0] - b_q;
  assign div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0]   step, fin_sel, fin_neg;
  logic [XLEN-1:0]     fin_res;
  assign step    = f3_q[2] ? div_next : mul_next;
  assign fin_sel = f3_q[2] ? {{XLEN{1'b0}}, (f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0])}
                           : step;

  rv32_muldiv_negate #(.W(2*XLEN)) u_fix (.i_neg(neg_q), .i_val(fin_sel), .o_val(fin_neg));

  assign fin_res = (f3_q[2] || f3_q == F3_MUL) ? fin_neg[XLEN-1:0] : fin_neg[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;

    case (state_q)
      MD_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = MD_DONE;
          res_d   = fin_res;
          cnt_d   = '0;
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (accept) begin
      f3_d  = i_funct3;
      rd_d  = i_rd;
      a_d   = mag1;
      b_d   = mag2;
      cnt_d = '0;
      neg_d = (i_funct3[2] && is_rem_in) ? s1 : (s1 ^ s2);
      acc_d = i_funct3[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
      if (div_zero) begin
        state_d = MD_DONE;
        res_d   = is_rem_in ? i_rs1 : '1;
      end else if (div_ovf) begin
        state_d = MD_DONE;
        res_d   = is_rem_in ? '0 : i_rs1;
      end else begin
        state_d = MD_CALC;
      end
    end

    if (i_flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MD_IDLE;
      f3_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign o_busy   = (state_q == MD_CALC);
  assign o_valid  = (state_q == MD_DONE);
  assign o_write  = o_valid && (rd_q != 5'd0);
  assign o_rd     = rd_q;
  assign o_result = res_q;

endmodule

// File: tb/tb_rv32_muldiv.sv
// tb/tb_rv32_muldiv.sv - directed self-checking bench for rv32_muldiv
module tb_rv32_muldiv;
  import rv32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2;
  logic [4:0]  i_rd;
  logic        o_busy, o_valid, o_write;
  logic [4:0]  o_rd;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_muldiv dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_funct3(i_funct3),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
    .o_busy(o_busy), .o_valid(o_valid), .o_write(o_write), .o_rd(o_rd), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
    i_rd     = rd;
    i_start  = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output int busy);
    cycles = 1;
    busy   = 0;
    while (!o_valid && cycles < 100) begin
      if (o_busy) busy++;
      @(posedge i_clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_cycles);
    int c, bz;
    @(negedge i_clk);
    start_op(f3, a, b, rd);
    wait_valid(c, bz);
    check({tag, " latency"}, 32'(c), 32'(exp_cycles));
    check({tag, " result"}, o_result, exp_res);
  endtask

  initial begin
    int c, bz, nvalid;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_funct3 = 3'd0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_rd     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset write", 32'(o_write), 32'd0);
    check("reset rd", 32'(o_rd), 32'd0);
    check("reset result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // MUL 7 x -3 with full latency/handshake checks
    @(negedge i_clk);
    start_op(F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    wait_valid(c, bz);
    check("mul latency", 32'(c), 32'd33);
    check("mul busy cycles", 32'(bz), 32'd32);
    check("mul result", o_result, 32'hFFFF_FFEB);
    check("mul write", 32'(o_write), 32'd1);
    check("mul rd", 32'(o_rd), 32'd5);
    @(posedge i_clk);
    #1;
    check("mul valid one cycle", 32'(o_valid), 32'd0);
    check("mul result held", o_result, 32'hFFFF_FFEB);

    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 33);
    run_op("mulhsu", F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 33);
    run_op("mulhu",  F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h7FFF_FFFF, 33);
    run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",   F3_DIVU,   32'd100,       32'd7,         5'd2, 32'd14,        33);
    run_op("remu",   F3_REMU,   32'd100,       32'd7,         5'd2, 32'd2,         33);

    run_op("div by zero", F3_DIV, 32'h1234_5678, 32'd0,         5'd3, 32'hFFFF_FFFF, 1);
    run_op("rem by zero", F3_REM, 32'd5,         32'd0,         5'd3, 32'd5,         1);
    run_op("div ovf",     F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1);
    run_op("rem ovf",     F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'd0,         1);

    // Start pulsed mid-CALC is ignored
    @(negedge i_clk);
    start_op(F3_DIVU, 32'd100, 32'd7, 5'd3);
    repeat (5) @(posedge i_clk);
    #1;
    start_op(F3_MUL, 32'd9, 32'd9, 5'd7);
    wait_valid(c, bz);
    check("ignored start result", o_result, 32'd14);
    check("ignored start rd", 32'(o_rd), 32'd3);

    // Flush at iteration 10
    @(negedge i_clk);
    start_op(F3_DIVU, 32'd100, 32'd7, 5'd4);
    repeat (10) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    check("flush busy", 32'(o_busy), 32'd0);
    check("flush valid", 32'(o_valid), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) nvalid++;
    end
    check("flush no valid", 32'(nvalid), 32'd0);

    // Flush together with start drops the start
    @(negedge i_clk);
    i_funct3 = F3_DIV; i_rs1 = 32'd1; i_rs2 = 32'd0; i_rd = 5'd9;
    i_start = 1'b1; i_flush = 1'b1;
    @(posedge i_clk);
    #1 begin i_start = 1'b0; i_flush = 1'b0; end
    check("flush+start valid", 32'(o_valid), 32'd0);
    check("flush+start busy", 32'(o_busy), 32'd0);

    // Back-to-back start in the DONE cycle
    @(negedge i_clk);
    start_op(F3_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    wait_valid(c, bz);
    check("b2b first result", o_result, 32'h7FFF_FFFF);
    start_op(F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd8);
    wait_valid(c, bz);
    check("b2b second latency", 32'(c), 32'd33);
    check("b2b second result", o_result, 32'hFFFF_FFEB);
    check("b2b second rd", 32'(o_rd), 32'd8);

    // rd = 0: valid without register-file write
    run_op("rd0", F3_MUL, 32'd6, 32'd7, 5'd0, 32'd42, 33);
    check("rd0 valid", 32'(o_valid), 32'd1);
    check("rd0 write", 32'(o_write), 32'd0);

    // Async reset mid-CALC, between clock edges
    @(negedge i_clk);
    start_op(F3_MUL, 32'd3, 32'd5, 5'd9);
    repeat (5) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(o_busy), 32'd0);
    check("async rst valid", 32'(o_valid), 32'd0);
    check("async rst result", o_result, 32'd0);
    check("async rst rd", 32'(o_rd), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("post-reset mul", F3_MUL, 32'd3, 32'd4, 5'd10, 32'd12, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_muldiv.md
Name: rv32_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two operands read from the integer register file (rs1/rs2 read data) plus funct3 and destination index.
- Produces a 32-bit result with write enable and address that feed the register file write port directly.
- Used for all eight M-extension ops; ALU ops bypass it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request; sampled only when the unit can accept.
- i_funct3  input  3  MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111.
- i_rs1  input  XLEN  operand 1 (rs1 read data).
- i_rs2  input  XLEN  operand 2 (rs2 read data).
- i_rd  input  5  destination register index.
- i_flush  input  1  pipeline kill; aborts any operation.
- o_busy  output  1  high in CALC; a new i_start is not accepted.
- o_valid  output  1  one-cycle result strobe.
- o_write  output  1  o_valid && o_rd != 0; drives register file write enable.
- o_rd  output  5  destination index of the completed op.
- o_result  output  XLEN  result; held stable until the next accepted start.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE; o_busy, o_valid and o_write = 0; o_result and o_rd = 0; counter = 0.
- States: IDLE, CALC, DONE.
  - IDLE: on i_start, latch funct3/rd and operand magnitudes/signs, then go to CALC (counter=0) or to DONE (special case).
  - CALC: one iteration per edge. When counter reaches XLEN-1, go to DONE at that edge.
  - DONE: o_valid=1 for exactly this cycle. Next edge: i_start accepted (→CALC or DONE), else →IDLE.
- Latency, with start sampled at edge E0:
  - Normal ops: iterations occur at E1..E32 and o_valid is high in the cycle after E32 (33 cycles).
  - Special cases: o_valid is high in the cycle after E0 (1 cycle).
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are used internally, with the sign applied at completion.
- Multiply:
  - 64-bit unsigned shift-add over 32 iterations.
  - Negate the product if the operand signs differ.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Divide:
  - Restoring, 1 quotient bit per iteration.
  - Quotient sign = sign1^sign2 (signed ops). Remainder sign = dividend sign.
- Special cases (no iteration):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- i_start while o_busy is ignored; the upstream stage must stall on o_busy.
- i_flush: any state → IDLE at the next edge; o_valid and o_write are 0 in the following cycle.
  - i_flush together with i_start: flush wins and the start is dropped.
  - i_flush in the DONE cycle does not mask that cycle's o_valid.
- o_rd is held along with o_result. o_write is never asserted for rd=0, because the register file has no storage at index 0.

Decomposition:
- Shared core package (rv32_pkg):
  - funct3 M-op constants.
  - muldiv state enum.
  - XLEN constant.
- Optional sub-module rv32_muldiv_negate: conditional two's-complement of 64/32 bits, used for input magnitude and output sign fix.
- FSM and datapath stay in one module.

Test Plan:
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), rd=5:
  - o_valid exactly 33 cycles after start; o_result=0xFFFFFFEB; o_write=1; o_rd=5.
  - o_busy high for 32 cycles.
- MULH / MULHSU / MULHU with 0x80000000 × 0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHSU → 0x80000000.
  - MULHU → 0x7FFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with o_valid exactly 1 cycle after start:
  - DIV x/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM same operands → 0.
- Control handshakes:
  - i_start pulsed mid-CALC: ignored, and the result matches the first op.
  - i_flush at iteration 10: no o_valid; IDLE in the next cycle.
  - Back-to-back start in the DONE cycle: accepted, and the second result arrives 33 cycles later.
- Async reset asserted mid-CALC, with no clock edge:
  - Outputs go to 0 immediately.
  - After release, MUL 3×4 returns 12.
- Op with rd=0: o_valid=1, o_write=0.
